// File: rtl/spi_ep_pkg.sv
// spi_ep_pkg: shared types, widths and key-length helpers for the SPI block endpoint
package spi_ep_pkg;
    typedef enum logic [2:0] {IDLE, RX_BLK, RX_KEY, GAP_W, TX, FIN} ep_state_t;
    localparam int BLOCK_W = 128;
    localparam int NK_LEGAL [3] = '{4, 6, 8};
    function automatic int key_w(input int nk);
        return nk * 32;
    endfunction
    function automatic bit nk_legal(input int nk);
        return nk == NK_LEGAL[0] || nk == NK_LEGAL[1] || nk == NK_LEGAL[2];
    endfunction
endpackage

// File: rtl/spi_shift_tx.sv
// spi_shift_tx: 128-bit parallel-load, MSB-first shift register feeding sdo
module spi_shift_tx
    import spi_ep_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [BLOCK_W-1:0] d,
    output logic               msb
);
    logic [BLOCK_W-1:0] q;
    assign msb = q[BLOCK_W-1];
    // load has priority so a fresh result is never shifted on its capture edge
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= d;
        else if (shift)
            q <= {q[BLOCK_W-2:0], 1'b0};
    end
endmodule

// File: rtl/spi_block_endpoint.sv
// spi_block_endpoint: SPI slave receiving block+key, driving the AES core handshake and streaming the result; SPI_EP_LOOPBACK_EN bypasses the core
module spi_block_endpoint
    import spi_ep_pkg::*;
#(
    parameter int NK  = 4,
    parameter int GAP = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  sdi,
    output logic                  sdo,
    output logic                  core_start,
    output logic [BLOCK_W-1:0]    core_block,
    output logic [key_w(NK)-1:0]  core_key,
    input  logic                  core_done,
    input  logic [BLOCK_W-1:0]    core_result,
    output logic                  busy,
    output logic                  late
);
    localparam int KEY_W = key_w(NK);

    ep_state_t          state, state_n;
    logic [7:0]         cnt, cnt_n;
    logic               rx_blk, rx_key, last_key, gap_end, load, shift, late_set, have_res, tx_msb;
    logic [BLOCK_W-1:0] tx_d;

    assign busy     = state != IDLE;
    assign rx_blk   = !cs && (state == IDLE || state == RX_BLK);
    assign rx_key   = !cs && state == RX_KEY;
    assign last_key = rx_key && cnt == 8'(KEY_W - 1);
    assign gap_end  = !cs && state == GAP_W && cnt == 8'(GAP - 1);
    assign shift    = !cs && state == TX && !late;

`ifdef SPI_EP_LOOPBACK_EN
    logic unused_core;
    assign unused_core = ^{core_done, core_result, gap_end};
    assign load     = !cs && state == GAP_W && cnt == 8'd0;
    assign tx_d     = core_block ^ core_key[KEY_W-1 -: BLOCK_W];
    assign late_set = 1'b0;
`else
    assign load     = !cs && state == GAP_W && core_done && !have_res;
    assign tx_d     = core_result;
    assign late_set = gap_end && !have_res && !load;
`endif

    // state and bit counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // next state and counter; cs high aborts any frame outside IDLE/FIN
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 8'd1;
        if (cs && busy && state != FIN) begin
            state_n = IDLE;
            cnt_n   = 8'd0;
        end else begin
            case (state)
                IDLE:    begin state_n = cs ? IDLE : RX_BLK; cnt_n = cs ? 8'd0 : 8'd1; end
                RX_BLK:  if (cnt == 8'(BLOCK_W - 1)) begin state_n = RX_KEY; cnt_n = 8'd0; end
                RX_KEY:  if (last_key) begin state_n = GAP_W; cnt_n = 8'd0; end
                GAP_W:   if (gap_end) begin state_n = TX; cnt_n = 8'd0; end
                TX:      if (cnt == 8'(BLOCK_W - 1)) begin state_n = FIN; cnt_n = 8'd0; end
                default: begin state_n = IDLE; cnt_n = 8'd0; end
            endcase
        end
    end

    // capture shifting, start pulse, result bookkeeping and sdo register
    always_ff @(posedge clk) begin
        if (rst) begin
            sdo        <= 1'b0;
            core_start <= 1'b0;
            core_block <= '0;
            core_key   <= '0;
            late       <= 1'b0;
            have_res   <= 1'b0;
        end else begin
            core_start <= last_key;
            sdo        <= shift & tx_msb;
            if (rx_blk) core_block <= {core_block[BLOCK_W-2:0], sdi};
            if (rx_key) core_key <= {core_key[KEY_W-2:0], sdi};
            if (state == IDLE && !cs) begin
                late     <= 1'b0;
                have_res <= 1'b0;
            end
            if (load) have_res <= 1'b1;
            if (late_set) late <= 1'b1;
        end
    end

    spi_shift_tx u_tx (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .d     (tx_d),
        .msb   (tx_msb)
    );
endmodule

// File: tb/tb_spi_block_endpoint.sv
// tb_spi_block_endpoint: randomized frames checked every cycle against a frame-level timing model
module tb_spi_block_endpoint #(
    parameter int NK  = 4,
    parameter int GAP = 4
);
    localparam int KW   = NK * 32;
    localparam int LAST = 127 + KW;
    localparam int TX0  = LAST + GAP;

    logic           clk = 1'b0;
    logic           rst, cs, sdi, core_done;
    logic [127:0]   core_result;
    logic           sdo, core_start, busy, late;
    logic [127:0]   core_block;
    logic [KW-1:0]  core_key;

    logic           e_sdo, e_start, e_busy, e_late;
    logic [127:0]   e_blk;
    logic [KW-1:0]  e_key;
    bit             chk = 0, chk_data = 0;
    int             n_chk = 0, n_pass = 0;

    spi_block_endpoint #(.NK(NK), .GAP(GAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .cs          (cs),
        .sdi         (sdi),
        .sdo         (sdo),
        .core_start  (core_start),
        .core_block  (core_block),
        .core_key    (core_key),
        .core_done   (core_done),
        .core_result (core_result),
        .busy        (busy),
        .late        (late)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [255:0] got, input logic [255:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    endtask

    function automatic logic [127:0] r128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [KW-1:0] rkey();
        logic [KW-1:0] k;
        for (int i = 0; i < NK; i++) k[i*32 +: 32] = $urandom();
        return k;
    endfunction

    // compare DUT outputs with the model on the falling edge of every cycle
    always @(negedge clk) if (chk) begin
        cmp("sdo", 256'(sdo), 256'(e_sdo));
        cmp("core_start", 256'(core_start), 256'(e_start));
        cmp("busy", 256'(busy), 256'(e_busy));
        cmp("late", 256'(late), 256'(e_late));
        if (chk_data) begin
            cmp("core_block", 256'(core_block), 256'(e_blk));
            cmp("core_key", 256'(core_key), 256'(e_key));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        chk = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1'b0; cs = 1'b1; sdi = 1'($urandom_range(0, 1));
            core_done = 1'($urandom_range(0, 1)); core_result = r128();
            tick();
            e_sdo = 1'b0; e_start = 1'b0; e_busy = 1'b0;
        end
    endtask

    // edge e of a frame: first block bit at e=0, last key bit at LAST, result bits after TX0
    task automatic run_frame(input logic [127:0] blk, input logic [KW-1:0] key, input logic [127:0] res,
                             input int dd, input bit lvl, input int abort_at, input int rst_at,
                             output logic [127:0] got, output int starts);
        bit ok;
        ok = dd >= 1 && dd <= GAP;
`ifdef SPI_EP_LOOPBACK_EN
        res = blk ^ key[KW-1 -: 128];
        ok  = 1'b1;
`endif
        got = '0;
        starts = 0;
        for (int e = 0; e <= TX0 + 128; e++) begin
            cs  = (e == abort_at);
            rst = (e == rst_at);
            sdi = e < 128 ? blk[127-e] : (e <= LAST ? key[LAST-e] : 1'($urandom_range(0, 1)));
            core_done   = lvl ? (e >= LAST + dd) : (e == LAST + dd);
            core_result = (e == LAST + dd) ? res : r128();
            tick();
            if (e == rst_at) begin
                rst = 1'b0;
                e_sdo = 1'b0; e_start = 1'b0; e_busy = 1'b0; e_late = 1'b0;
                e_blk = '0; e_key = '0; chk_data = 1;
                return;
            end
            if (e == abort_at) begin
                e_sdo = 1'b0; e_start = 1'b0; e_busy = 1'b0; chk_data = 0;
                return;
            end
            e_busy   = 1'b1;
            e_start  = (e == LAST);
            e_late   = (e >= TX0) && !ok;
            e_sdo    = (e > TX0 && ok) ? res[127-(e-TX0-1)] : 1'b0;
            chk_data = e >= LAST;
            e_blk    = blk;
            e_key    = key;
            if (e > TX0) got[127-(e-TX0-1)] = sdo;
            starts += int'(core_start);
        end
        cs = 1'b1; core_done = 1'b0;
        tick();
        e_sdo = 1'b0; e_start = 1'b0; e_busy = 1'b0;
    endtask

    initial begin
        logic [127:0] kb, res, got;
        logic [KW-1:0] kk;
        int starts, ab;
        rst = 1'b1; cs = 1'b1; sdi = 1'b0; core_done = 1'b0; core_result = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            e_sdo = 1'b0; e_start = 1'b0; e_busy = 1'b0; e_late = 1'b0;
            e_blk = '0; e_key = '0; chk_data = 1;
        end
        idle(3);

        kb = 128'h00112233445566778899aabbccddeeff;
        kk = '0;
        kk[KW-1 -: 128] = 128'h000102030405060708090a0b0c0d0e0f;
        run_frame(kb, kk, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3, 1'b0, -1, -1, got, starts);
`ifdef SPI_EP_LOOPBACK_EN
        cmp("pin_stream", 256'(got), 256'(128'h00102030405060708090a0b0c0d0e0f0));
`else
        cmp("pin_stream", 256'(got), 256'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));
`endif
        cmp("pin_start_pulses", 256'(starts), 256'(1));
        cmp("pin_late_ok", 256'(late), 256'(0));
        idle(3);

        run_frame(r128(), rkey(), r128(), GAP + 6, 1'b1, -1, -1, got, starts);
`ifdef SPI_EP_LOOPBACK_EN
        cmp("pin_late_loopback", 256'(late), 256'(0));
`else
        cmp("pin_late_set", 256'(late), 256'(1));
        cmp("pin_late_stream", 256'(got), 256'(0));
`endif
        idle(2);
        run_frame(r128(), rkey(), r128(), 2, 1'b0, -1, -1, got, starts);
        cmp("pin_late_cleared", 256'(late), 256'(0));
        idle(2);

        run_frame(r128(), rkey(), r128(), 2, 1'b0, 60, -1, got, starts);
        cmp("pin_abort_busy", 256'(busy), 256'(0));
        cmp("pin_abort_start", 256'(starts), 256'(0));
        idle(2);
        run_frame(r128(), rkey(), r128(), 1, 1'b1, -1, -1, got, starts);
        cmp("pin_after_abort_start", 256'(starts), 256'(1));
        idle(2);

        for (int f = 0; f < 10; f++) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TX0 + 128)) : -1;
            run_frame(r128(), rkey(), r128(), int'($urandom_range(1, GAP + 6)),
                      1'($urandom_range(0, 1)), ab, -1, got, starts);
            idle(int'($urandom_range(1, 4)));
        end

        run_frame(r128(), rkey(), r128(), 2, 1'b0, -1, TX0 + 50, got, starts);
        cmp("pin_rst_block", 256'(core_block), 256'(0));
        cmp("pin_rst_sdo", 256'(sdo), 256'(0));
        cmp("pin_rst_busy", 256'(busy), 256'(0));
        idle(3);
        run_frame(r128(), rkey(), r128(), GAP, 1'b1, -1, -1, got, starts);
        idle(2);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
